// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC and drives a
// request/ready instruction-memory handshake. A one-entry buffer absorbs stalls.
module if_id_stage #(
    parameter int unsigned     word     = 32,
    parameter int unsigned     rwidth   = 5,
    parameter logic [word-1:0] PC_RESET = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              IF_ID_Stall,
    input  logic              Branch_Taken,
    input  logic [word-1:0]   Branch_Target,
    output logic              IMem_Req,
    output logic [word-1:0]   IMem_Addr,
    input  logic              IMem_Ready,
    input  logic [word-1:0]   IMem_Rdata,
    output logic [word-1:0]   ID_PC_plus4,
    output logic [word-1:0]   ID_Instruction,
    output logic              ID_Valid,
    output logic [rwidth-1:0] IF_ID_RegisterRs,
    output logic [rwidth-1:0] IF_ID_RegisterRt,
    output logic [rwidth-1:0] IF_ID_RegisterRd
);

    localparam logic [word-1:0] Step = word'(PC_STEP);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e            state_q, state_d;
    logic [word-1:0]   pc_q, pc_d;
    logic [word-1:0]   id_pc4_q, id_pc4_d;
    logic [word-1:0]   id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;
    logic [word-1:0]   hold_instr_q, hold_instr_d;
    logic [word-1:0]   hold_pc4_q, hold_pc4_d;
    logic              redir_pend_q, redir_pend_d;
    logic [word-1:0]   redir_tgt_q, redir_tgt_d;
    logic [word-1:0]   pc_plus;

    assign pc_plus = pc_q + Step;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (IMem_Ready) begin
                    if (Branch_Taken || redir_pend_q) begin
                        // Returned word belongs to the wrong path; restart at the target.
                        pc_d         = Branch_Taken ? Branch_Target : redir_tgt_q;
                        id_instr_d   = '0;
                        id_valid_d   = 1'b0;
                        redir_pend_d = 1'b0;
                    end else if (IF_ID_Stall) begin
                        hold_instr_d = IMem_Rdata;
                        hold_pc4_d   = pc_plus;
                        state_d      = StHold;
                    end else begin
                        id_pc4_d   = pc_plus;
                        id_instr_d = IMem_Rdata;
                        id_valid_d = 1'b1;
                        pc_d       = pc_plus;
                    end
                end else if (Branch_Taken) begin
                    // Request in flight cannot be aborted; remember where to go afterwards.
                    redir_tgt_d  = Branch_Target;
                    redir_pend_d = 1'b1;
                    id_instr_d   = '0;
                    id_valid_d   = 1'b0;
                end else if (!IF_ID_Stall) begin
                    id_instr_d = '0;
                    id_valid_d = 1'b0;
                end
            end
            StHold: begin
                if (Branch_Taken) begin
                    pc_d         = Branch_Target;
                    hold_instr_d = '0;
                    hold_pc4_d   = '0;
                    id_instr_d   = '0;
                    id_valid_d   = 1'b0;
                    state_d      = StFetch;
                end else if (!IF_ID_Stall) begin
                    id_pc4_d   = hold_pc4_q;
                    id_instr_d = hold_instr_q;
                    id_valid_d = 1'b1;
                    pc_d       = pc_plus;
                    state_d    = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            pc_q         <= PC_RESET;
            id_pc4_q     <= '0;
            id_instr_q   <= '0;
            id_valid_q   <= 1'b0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    assign IMem_Req         = (state_q == StFetch);
    assign IMem_Addr        = pc_q;
    assign ID_PC_plus4      = id_pc4_q;
    assign ID_Instruction   = id_instr_q;
    assign ID_Valid         = id_valid_q;
    assign IF_ID_RegisterRs = id_instr_q[21 +: rwidth];
    assign IF_ID_RegisterRt = id_instr_q[16 +: rwidth];
    assign IF_ID_RegisterRd = id_instr_q[11 +: rwidth];

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and a variable-latency instruction-memory request/ready handshake.
- Absorbs hazard-unit stalls with a one-entry hold buffer and applies branch redirects from ID.
- Feeds the ID stage, i.e. register-file reads, decode and the Rs/Rt/Rd fields consumed by the ID/EX register.

Parameters:
word, 32, instruction/PC width
rwidth, 5, register-number width
PC_RESET, 32'h0000_0000, PC value after reset
PC_STEP, 4, sequential PC increment

Ports:
Clock  in  1  pipeline clock, all state on rising edge
Reset_n  in  1  synchronous active-low reset
IF_ID_Stall  in  1  hazard-unit stall; holds PC and IF/ID contents
Branch_Taken  in  1  ID-stage branch/jump resolved taken; single-cycle pulse
Branch_Target  in  word  redirect PC, valid with Branch_Taken
IMem_Req  out  1  fetch request
IMem_Addr  out  word  fetch address (= PC)
IMem_Ready  in  1  memory data valid / request accepted; meaningful only while IMem_Req=1
IMem_Rdata  in  word  instruction, valid with IMem_Ready
ID_PC_plus4  out  word  PC+PC_STEP of the instruction in ID
ID_Instruction  out  word  instruction in ID
ID_Valid  out  1  1 = real instruction, 0 = bubble
IF_ID_RegisterRs  out  rwidth  ID_Instruction[25:21]
IF_ID_RegisterRt  out  rwidth  ID_Instruction[20:16]
IF_ID_RegisterRd  out  rwidth  ID_Instruction[15:11]

Behaviour:
- Reset (Reset_n=0 at edge):
  - PC=PC_RESET; state=S_IDLE.
  - IMem_Req=0; ID_PC_plus4=0; ID_Instruction=0; ID_Valid=0.
  - Hold buffer, redirect_pending and saved target cleared.
  - Reset overrides every other input. An outstanding request is abandoned; dropping Req is legal, and the memory ignores it.
- IF_ID_Register* are combinational slices of the ID_Instruction register; they read 0 for a bubble.
- Decision priority each edge: reset > redirect > stall > normal.
- Pipeline latency: an instruction returned with Ready at edge N appears on ID_* after edge N (one register).
- S_IDLE:
  - IMem_Req=0.
  - Next state S_FETCH.
  - Branch_Taken is ignored here; it cannot occur, since ID holds a bubble.
- S_FETCH:
  - IMem_Req=1, IMem_Addr=PC. Req and Addr stay stable until Ready.
  - Ready=1, and Branch_Taken or redirect_pending:
    - discard Rdata;
    - PC=Branch_Target (or the saved target);
    - IF/ID loads a bubble;
    - clear redirect_pending;
    - stay in S_FETCH.
  - Ready=1, IF_ID_Stall=1:
    - capture Rdata and PC+PC_STEP into the hold buffer;
    - PC and IF/ID unchanged;
    - go to S_HOLD.
  - Ready=1, no stall: IF/ID={PC+PC_STEP, Rdata, valid=1}; PC+=PC_STEP.
  - Ready=0, Branch_Taken=1:
    - save Branch_Target and set redirect_pending; the request cannot be aborted;
    - IF/ID loads a bubble.
  - Ready=0, no redirect: if IF_ID_Stall=1, hold IF/ID; else IF/ID loads a bubble.
- S_HOLD:
  - IMem_Req=0.
  - Branch_Taken=1: drop the buffer; PC=Branch_Target; IF/ID bubble; go to S_FETCH.
  - IF_ID_Stall=1: hold everything.
  - IF_ID_Stall=0: IF/ID=buffer (valid=1); PC+=PC_STEP; go to S_FETCH.
- PC arithmetic: modulo 2^word; 32'hFFFF_FFFC+4 wraps to 0 silently.
- Branch_Target low bits are taken as given; no alignment check.
- Bubble definition: ID_Valid=0, ID_Instruction=0 (sll $0 nop), ID_PC_plus4 unchanged.

Test Plan:
- Zero-wait fetch: Reset_n=0 for 2 cycles, release, Ready tied 1, Rdata=addr-derived pattern → IMem_Addr 0,4,8,…; ID_Instruction matches the previous cycle's Rdata; ID_Valid=1 from the 3rd cycle; Rs/Rt/Rd = fields of 32'h012A4020 (9,10,8).
- Wait states: Ready asserted every 3rd cycle → Req/Addr held stable; ID_Valid=0 on non-Ready cycles; each instruction appears exactly once.
- Stall: IF_ID_Stall=1 for 3 cycles coincident with Ready on addr 0x10 → ID contents frozen; S_HOLD with Req=0; on release ID gets the 0x10 instruction with ID_PC_plus4=0x14, next fetch at 0x14.
- Branch during wait: Branch_Taken with Target=0x100 while the 0x20 request is not Ready; Ready 2 cycles later → data discarded; ID bubble; next IMem_Addr=0x100.
- Branch in S_HOLD plus simultaneous stall: Branch_Taken=1 and IF_ID_Stall=1 in the same cycle → redirect wins; PC=Target, buffer dropped, ID bubble.
- Reset mid-fetch and wrap: Reset_n=0 while Req pending → next cycle Req=0, PC=0, ID_Valid=0. Separately, branch to 0xFFFFFFFC → next fetch address 0x0.
